mem_port_arbiter: RTL and testbench

Two-master arbiter that shares the single external memory port between the instruction-side and data-side cache controllers. Each master drives the same strobe/ready bus it would otherwise drive to memory. The arbiter grants one master at a time, holds the grant until that master's transaction completes with `m_ready`, and alternates on contention. It sits between the L1/L2 cache controllers and the AXI/SRAM bridge.

---
 rtl/cache_pkg.sv | 13 +
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Types and constants shared by the cache controllers and the memory-port arbiter.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
    localparam logic [3:0] WEN_ALL       = 4'hF;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the external memory port between the instruction- and data-side cache
// controllers: one owner at a time, grant held until m_ready, round-robin on ties.
module mem_port_arbiter
    import cache_pkg::*;
#(
    parameter int A_WIDTH = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,

    input  logic [A_WIDTH-1:0] i_m_a,
    input  logic [31:0]        i_m_din,
    input  logic               i_m_strobe,
    input  logic [3:0]         i_m_wen,
    input  logic [1:0]         i_m_size,
    input  logic               i_m_rw,
    output logic [31:0]        i_m_dout,
    output logic               i_m_ready,

    input  logic [A_WIDTH-1:0] d_m_a,
    input  logic [31:0]        d_m_din,
    input  logic               d_m_strobe,
    input  logic [3:0]         d_m_wen,
    input  logic [1:0]         d_m_size,
    input  logic               d_m_rw,
    output logic [31:0]        d_m_dout,
    output logic               d_m_ready,

    output logic [A_WIDTH-1:0] m_a,
    output logic [31:0]        m_din,
    output logic               m_strobe,
    output logic [3:0]         m_wen,
    output logic [1:0]         m_size,
    output logic               m_rw,
    input  logic [31:0]        m_dout,
    input  logic               m_ready,

    output logic               grant_i,
    output logic               grant_d,
    output logic               timeout
);

    arb_state_t state, next_state;
    logic       last, next_last;   // 0 = I owned last, 1 = D owned last

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b0;
        end else begin
            state <= next_state;
            last  <= next_last;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        next_last  = last;
        unique case (state)
            IDLE: begin
                if (i_m_strobe && d_m_strobe)
                    next_state = last ? GNT_I : GNT_D;
                else if (i_m_strobe)
                    next_state = GNT_I;
                else if (d_m_strobe)
                    next_state = GNT_D;
            end
            GNT_I: begin
                if (m_ready) begin
                    next_state = IDLE;
                    next_last  = 1'b0;
                end else if (!i_m_strobe) begin
                    next_state = IDLE;   // master abandoned its request
                end
            end
            GNT_D: begin
                if (m_ready) begin
                    next_state = IDLE;
                    next_last  = 1'b1;
                end else if (!d_m_strobe) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Memory side follows the owner; nothing from a strobe reaches m_strobe in IDLE.
    always_comb begin
        m_a       = '0;
        m_din     = '0;
        m_strobe  = 1'b0;
        m_wen     = '0;
        m_size    = '0;
        m_rw      = 1'b0;
        i_m_ready = 1'b0;
        d_m_ready = 1'b0;
        unique case (state)
            GNT_I: begin
                m_a       = i_m_a;
                m_din     = i_m_din;
                m_strobe  = i_m_strobe;
                m_wen     = i_m_wen;
                m_size    = i_m_size;
                m_rw      = i_m_rw;
                i_m_ready = m_ready;
            end
            GNT_D: begin
                m_a       = d_m_a;
                m_din     = d_m_din;
                m_strobe  = d_m_strobe;
                m_wen     = d_m_wen;
                m_size    = d_m_size;
                m_rw      = d_m_rw;
                d_m_ready = m_ready;
            end
            default: ;
        endcase
    end

    assign i_m_dout = m_dout;
    assign d_m_dout = m_dout;
    assign grant_i  = (state == GNT_I);
    assign grant_d  = (state == GNT_D);

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam int            CW       = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
            localparam logic [CW-1:0] CNT_FIRE = CW'(TIMEOUT - 1);

            // Counts completed grant cycles; saturation makes the pulse one-shot.
            logic [CW-1:0] cnt;

            always_ff @(posedge clk) begin
                if (rst || state == IDLE || next_state == IDLE)
                    cnt <= '0;
                else if (cnt != CNT_MAX)
                    cnt <= cnt + 1'b1;
            end

            assign timeout = (state != IDLE) && !m_ready && (cnt == CNT_FIRE);
        end else begin : g_no_wdog
            assign timeout = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration order, muxing, reset and watchdog.
module tb_mem_port_arbiter;
    import cache_pkg::*;

    localparam int AW = 32;
    localparam logic [AW-1:0] I_ADDR = 32'h1FC0_0000;
    localparam logic [AW-1:0] D_ADDR = 32'h8000_0100;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] i_m_a, d_m_a, m_a;
    logic [31:0]   i_m_din, d_m_din, m_din;
    logic          i_m_strobe, d_m_strobe, m_strobe;
    logic [3:0]    i_m_wen, d_m_wen, m_wen;
    logic [1:0]    i_m_size, d_m_size, m_size;
    logic          i_m_rw, d_m_rw, m_rw;
    logic [31:0]   i_m_dout, d_m_dout, m_dout;
    logic          i_m_ready, d_m_ready, m_ready;
    logic          grant_i, grant_d, timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.A_WIDTH(AW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .i_m_a(i_m_a), .i_m_din(i_m_din), .i_m_strobe(i_m_strobe), .i_m_wen(i_m_wen),
        .i_m_size(i_m_size), .i_m_rw(i_m_rw), .i_m_dout(i_m_dout), .i_m_ready(i_m_ready),
        .d_m_a(d_m_a), .d_m_din(d_m_din), .d_m_strobe(d_m_strobe), .d_m_wen(d_m_wen),
        .d_m_size(d_m_size), .d_m_rw(d_m_rw), .d_m_dout(d_m_dout), .d_m_ready(d_m_ready),
        .m_a(m_a), .m_din(m_din), .m_strobe(m_strobe), .m_wen(m_wen), .m_size(m_size),
        .m_rw(m_rw), .m_dout(m_dout), .m_ready(m_ready),
        .grant_i(grant_i), .grant_d(grant_d), .timeout(timeout)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_m_a = I_ADDR; d_m_a = D_ADDR;
        i_m_din = 32'h0; d_m_din = 32'h0;
        i_m_strobe = 1'b0; d_m_strobe = 1'b0;
        i_m_wen = 4'h0; d_m_wen = 4'h0;
        i_m_size = 2'b00; d_m_size = 2'b00;
        i_m_rw = 1'b0; d_m_rw = 1'b0;
        m_dout = 32'hA5A5_5A5A; m_ready = 1'b0;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({m_a, m_din, m_strobe, m_wen, m_size, m_rw, i_m_ready, d_m_ready,
             grant_i, grant_d, timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: m_a=%h m_strobe=%b grant_i=%b grant_d=%b timeout=%b, required all zero",
                     m_a, m_strobe, grant_i, grant_d, timeout);
        end
        checks++;
        if (i_m_dout !== 32'hA5A5_5A5A || d_m_dout !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL reset_dout: i=%h d=%h, required a5a55a5a", i_m_dout, d_m_dout);
        end
        step();
        rst = 1'b0;
        m_dout = 32'h0;
    endtask

    // Both strobes held high: D, I, D, I with one IDLE cycle between grants.
    task automatic test_tie_alternation();
        logic exp_d;
        i_m_strobe = 1'b1;
        d_m_strobe = 1'b1;
        step();
        for (int g = 0; g < 4; g++) begin
            exp_d   = (g % 2 == 0);
            m_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (grant_d !== exp_d || grant_i !== !exp_d) begin
                errors++;
                $display("FAIL tie_owner[%0d]: grant_i=%b grant_d=%b, required grant_d=%b", g, grant_i, grant_d, exp_d);
            end
            checks++;
            if (m_a !== (exp_d ? D_ADDR : I_ADDR) || m_strobe !== 1'b1) begin
                errors++;
                $display("FAIL tie_addr[%0d]: m_a=%h m_strobe=%b, required %h/1", g, m_a, m_strobe, exp_d ? D_ADDR : I_ADDR);
            end
            checks++;
            if (d_m_ready !== exp_d || i_m_ready !== !exp_d) begin
                errors++;
                $display("FAIL tie_ready[%0d]: i_m_ready=%b d_m_ready=%b, required d_m_ready=%b", g, i_m_ready, d_m_ready, exp_d);
            end
            step();
            m_ready = 1'b0;
            if (g == 3) begin
                i_m_strobe = 1'b0;
                d_m_strobe = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (grant_i !== 1'b0 || grant_d !== 1'b0 || m_strobe !== 1'b0) begin
                errors++;
                $display("FAIL tie_idle_gap[%0d]: grant_i=%b grant_d=%b m_strobe=%b, required 0/0/0", g, grant_i, grant_d, m_strobe);
            end
            step();
        end
    endtask

    task automatic test_i_read();
        int pulses = 0;
        i_m_a      = I_ADDR;
        i_m_rw     = 1'b0;
        i_m_strobe = 1'b1;
        step();
        for (int c = 1; c <= 4; c++) begin
            m_ready = (c == 4);
            m_dout  = (c == 4) ? 32'hDEAD_BEEF : 32'h0;
            @(negedge clk);
            checks++;
            if (m_strobe !== 1'b1 || m_a !== I_ADDR || d_m_ready !== 1'b0) begin
                errors++;
                $display("FAIL i_read_cycle[%0d]: m_strobe=%b m_a=%h d_m_ready=%b, required 1/%h/0", c, m_strobe, m_a, d_m_ready, I_ADDR);
            end
            if (i_m_ready === 1'b1) pulses++;
            if (c == 4) begin
                checks++;
                if (i_m_dout !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL i_read_data: i_m_dout=%h, required deadbeef", i_m_dout);
                end
            end
            step();
        end
        i_m_strobe = 1'b0;
        m_ready    = 1'b0;
        @(negedge clk);
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL i_read_ready_pulses: got %0d, required 1", pulses);
        end
        checks++;
        if (m_strobe !== 1'b0 || m_a !== '0 || grant_i !== 1'b0) begin
            errors++;
            $display("FAIL i_read_idle: m_strobe=%b m_a=%h grant_i=%b, required 0/0/0", m_strobe, m_a, grant_i);
        end
        step();
    endtask

    // last = I here, so the tie goes to D; I waits with its request pending.
    task automatic test_d_write();
        d_m_a = D_ADDR; d_m_din = 32'h1234_5678; d_m_wen = 4'b0011; d_m_size = 2'b01; d_m_rw = 1'b1;
        i_m_a = I_ADDR; i_m_din = 32'h0;         i_m_wen = WEN_ALL; i_m_size = MEM_SIZE_WORD; i_m_rw = 1'b0;
        i_m_strobe = 1'b1;
        d_m_strobe = 1'b1;
        step();
        for (int c = 1; c <= 2; c++) begin
            m_ready = (c == 2);
            @(negedge clk);
            checks++;
            if (grant_d !== 1'b1 || m_rw !== 1'b1 || m_wen !== 4'b0011 || m_din !== 32'h1234_5678 || m_size !== 2'b01) begin
                errors++;
                $display("FAIL d_write_bus[%0d]: grant_d=%b m_rw=%b m_wen=%b m_din=%h m_size=%b, required 1/1/0011/12345678/01",
                         c, grant_d, m_rw, m_wen, m_din, m_size);
            end
            checks++;
            if (i_m_ready !== 1'b0 || d_m_ready !== (c == 2)) begin
                errors++;
                $display("FAIL d_write_ready[%0d]: i_m_ready=%b d_m_ready=%b, required 0/%b", c, i_m_ready, d_m_ready, c == 2);
            end
            step();
        end
        m_ready    = 1'b0;
        d_m_strobe = 1'b0;
        @(negedge clk);
        checks++;
        if (m_rw !== 1'b0 || m_wen !== 4'b0000 || i_m_ready !== 1'b0 || grant_i !== 1'b0) begin
            errors++;
            $display("FAIL d_write_gap: m_rw=%b m_wen=%b i_m_ready=%b grant_i=%b, required 0/0000/0/0", m_rw, m_wen, i_m_ready, grant_i);
        end
        step();
        m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (grant_i !== 1'b1 || m_rw !== 1'b0 || m_wen !== WEN_ALL || m_size !== MEM_SIZE_WORD || i_m_ready !== 1'b1) begin
            errors++;
            $display("FAIL d_write_then_i: grant_i=%b m_rw=%b m_wen=%b m_size=%b i_m_ready=%b, required 1/0/1111/10/1",
                     grant_i, m_rw, m_wen, m_size, i_m_ready);
        end
        step();
        i_m_strobe = 1'b0;
        m_ready    = 1'b0;
        d_m_rw     = 1'b0;
        step();
    endtask

    // Make last = D, then reset during an I grant: last must return to I so D wins the next tie.
    task automatic test_reset_mid_grant();
        d_m_strobe = 1'b1;
        step();
        m_ready = 1'b1;
        step();
        d_m_strobe = 1'b0;
        m_ready    = 1'b0;
        i_m_strobe = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (grant_i !== 1'b1 || m_strobe !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: grant_i=%b m_strobe=%b, required 1/1", grant_i, m_strobe);
        end
        rst = 1'b1;
        step();
        rst        = 1'b0;
        d_m_strobe = 1'b1;
        @(negedge clk);
        checks++;
        if (m_strobe !== 1'b0 || grant_i !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drop: m_strobe=%b grant_i=%b, required 0/0", m_strobe, grant_i);
        end
        step();
        @(negedge clk);
        checks++;
        if (grant_d !== 1'b1 || grant_i !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_next_tie: grant_i=%b grant_d=%b, required 0/1", grant_i, grant_d);
        end
        m_ready = 1'b1;
        step();
        m_ready    = 1'b0;
        i_m_strobe = 1'b0;
        d_m_strobe = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int pulses = 0;
        i_m_strobe = 1'b1;
        step();
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (timeout === 1'b1) pulses++;
            checks++;
            if (timeout !== (c == 8) || grant_i !== 1'b1) begin
                errors++;
                $display("FAIL timeout_cycle[%0d]: timeout=%b grant_i=%b, required %b/1", c, timeout, grant_i, c == 8);
            end
            step();
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL timeout_pulses: got %0d, required 1", pulses);
        end
        m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (i_m_ready !== 1'b1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_late_ready: i_m_ready=%b timeout=%b, required 1/0", i_m_ready, timeout);
        end
        step();
        m_ready    = 1'b0;
        i_m_strobe = 1'b0;
        step();
        // A fresh grant must count from zero again.
        i_m_strobe = 1'b1;
        step();
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (timeout !== (c == 8)) begin
                errors++;
                $display("FAIL timeout_recount[%0d]: timeout=%b, required %b", c, timeout, c == 8);
            end
            step();
        end
        m_ready = 1'b1;
        step();
        m_ready    = 1'b0;
        i_m_strobe = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_tie_alternation();
        test_i_read();
        test_d_write();
        test_reset_mid_grant();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
